// File: rtl/axis_xy_input_port.sv
// rtl/axis_xy_input_port.sv - mesh router input port: flit FIFO, XY route lock, PMU counters
module axis_xy_input_port #(
  parameter int DATA_WIDTH = 40,
  parameter int ID_WIDTH   = 4,
  parameter int DEST_WIDTH = 4,
  parameter int USER_WIDTH = 4,
  parameter int X_BITS     = 2,
  parameter int X_COORD    = 0,
  parameter int Y_COORD    = 0,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic [ID_WIDTH-1:0]   s_tid,
  input  logic [DEST_WIDTH-1:0] s_tdest,
  input  logic [USER_WIDTH-1:0] s_tuser,
  input  logic                  s_tlast,
  output logic [4:0]            m_tvalid,
  input  logic [4:0]            m_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic [ID_WIDTH-1:0]   m_tid,
  output logic [DEST_WIDTH-1:0] m_tdest,
  output logic [USER_WIDTH-1:0] m_tuser,
  output logic                  m_tlast,
  output logic [CNT_WIDTH-1:0]  pmu_flits,
  output logic [CNT_WIDTH-1:0]  pmu_stall,
  input  logic                  pmu_clr
);

  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = AW + 1;
  localparam int Y_BITS = DEST_WIDTH - X_BITS;
  localparam int FW     = DATA_WIDTH + ID_WIDTH + DEST_WIDTH + USER_WIDTH + 1;

  localparam logic [CW-1:0]     FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [X_BITS-1:0] X_C      = X_BITS'(X_COORD);
  localparam logic [Y_BITS-1:0] Y_C      = Y_BITS'(Y_COORD);

  // Direction indices; one-hot position in m_tvalid
  localparam logic [2:0] DIR_LOCAL = 3'd0;
  localparam logic [2:0] DIR_EAST  = 3'd1;
  localparam logic [2:0] DIR_WEST  = 3'd2;
  localparam logic [2:0] DIR_NORTH = 3'd3;
  localparam logic [2:0] DIR_SOUTH = 3'd4;

  typedef enum logic {IDLE, LOCKED} state_t;

  logic [FW-1:0]        mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  state_t               state_q, state_d;
  logic [2:0]           route_q, route_d;
  logic [CNT_WIDTH-1:0] flits_q, flits_d, stall_q, stall_d;

  logic                  push, pop, head_valid, sel_ready;
  logic [FW-1:0]         head;
  logic [X_BITS-1:0]     dx;
  logic [Y_BITS-1:0]     dy;
  logic [2:0]            route_fn, route;
  logic [4:0]            route_oh;

  // Ready depends only on registered occupancy, never on downstream ready
  assign s_tready   = (count_q != FULL_CNT);
  assign head_valid = (count_q != '0);
  assign push       = s_tvalid && s_tready;

  assign head = mem_q[rd_ptr_q];
  assign {m_tdata, m_tid, m_tdest, m_tuser, m_tlast} = head;

  // XY route of the head flit: resolve X first, then Y, unsigned compares
  always_comb begin
    dx       = m_tdest[X_BITS-1:0];
    dy       = m_tdest[DEST_WIDTH-1:X_BITS];
    route_fn = DIR_LOCAL;
    if (dx > X_C)      route_fn = DIR_EAST;
    else if (dx < X_C) route_fn = DIR_WEST;
    else if (dy > Y_C) route_fn = DIR_NORTH;
    else if (dy < Y_C) route_fn = DIR_SOUTH;
  end

  assign route     = (state_q == LOCKED) ? route_q : route_fn;
  assign route_oh  = 5'(5'b00001 << route);
  assign m_tvalid  = head_valid ? route_oh : 5'b00000;
  assign sel_ready = |(route_oh & m_tready);
  assign pop       = head_valid && sel_ready;

  // FIFO pointer/occupancy update; pointers wrap on their natural width
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  // Packet route lock: head without tlast pins the route until the tail leaves
  always_comb begin
    state_d = state_q;
    route_d = route_q;
    if (pop) begin
      if (state_q == IDLE && !m_tlast) begin
        state_d = LOCKED;
        route_d = route_fn;
      end else if (state_q == LOCKED && m_tlast) begin
        state_d = IDLE;
      end
    end
  end

  // Saturating PMU counters; clear wins over increment
  always_comb begin
    flits_d = flits_q;
    stall_d = stall_q;
    if (pmu_clr) begin
      flits_d = '0;
      stall_d = '0;
    end else begin
      if (pop && flits_q != '1)                     flits_d = flits_q + 1'b1;
      if (head_valid && !sel_ready && stall_q != '1) stall_d = stall_q + 1'b1;
    end
  end

  assign pmu_flits = flits_q;
  assign pmu_stall = stall_q;

  // Flit storage; contents need no reset since occupancy guards every read
  always_ff @(posedge ACLK) begin
    if (push) mem_q[wr_ptr_q] <= {s_tdata, s_tid, s_tdest, s_tuser, s_tlast};
  end

  // Control state, FSM and counters
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= IDLE;
      route_q  <= DIR_LOCAL;
      flits_q  <= '0;
      stall_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      route_q  <= route_d;
      flits_q  <= flits_d;
      stall_q  <= stall_d;
    end
  end

endmodule

// File: doc/axis_xy_input_port.md
Name: axis_xy_input_port

Overview:
- Input port stage of the mesh router, directly downstream of the axi2axis_XY bridge's m_axis_req_o / m_axis_resp_o stream.
- Buffers incoming AXI-Stream flits in a small FIFO.
- Computes the XY route from TDEST of each packet's head flit and locks that route until TLAST.
- Presents the flit to one of five output directions and keeps built-in PMU counters for forwarded flits and stall cycles.

Parameters:
- DATA_WIDTH, 40, TDATA width (matches bridge AXIS_DATA_WIDTH)
- ID_WIDTH, 4, TID width
- DEST_WIDTH, 4, TDEST width; TDEST = {dest_y, dest_x}
- USER_WIDTH, 4, TUSER width
- X_BITS, 2, width of dest_x (low bits of TDEST); dest_y = TDEST[DEST_WIDTH-1:X_BITS]
- X_COORD, 0, this router's X coordinate
- Y_COORD, 0, this router's Y coordinate
- FIFO_DEPTH, 4, flit buffer depth, power of two, >=2
- CNT_WIDTH, 32, PMU counter width

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  async active-low reset
- s_tvalid  in  1  upstream flit valid
- s_tready  out  1  upstream ready
- s_tdata  in  DATA_WIDTH  flit data
- s_tid  in  ID_WIDTH  flit id
- s_tdest  in  DEST_WIDTH  destination {y,x}
- s_tuser  in  USER_WIDTH  user
- s_tlast  in  1  last flit of packet
- m_tvalid  out  5  one-hot per-direction valid: [0]LOCAL [1]EAST [2]WEST [3]NORTH [4]SOUTH
- m_tready  in  5  per-direction ready
- m_tdata/m_tid/m_tdest/m_tuser/m_tlast  out  as input  shared head-flit payload
- pmu_flits  out  CNT_WIDTH  flits forwarded since reset
- pmu_stall  out  CNT_WIDTH  cycles head valid but selected ready low
- pmu_clr  in  1  synchronous clear of both counters

Behaviour:
- Clocking and reset: one clock, ACLK. ARESETn is asynchronous, active-low.
- Reset clears:
  - FIFO pointers and count to 0
  - state to IDLE, route_q to LOCAL
  - pmu_flits and pmu_stall to 0
- Outputs during reset: m_tvalid=0, s_tready=1 (FIFO empty).
- FIFO:
  - Push when s_tvalid && s_tready.
  - s_tready = (count != FIFO_DEPTH), from registered count only; no combinational path from m_tready.
  - Pop when the selected direction handshakes.
  - Push and pop in the same cycle leaves count unchanged. Pointers wrap modulo FIFO_DEPTH.
- Latency: a flit pushed in cycle N is visible on m_* in cycle N+1 at earliest. No bypass.
- Route function (combinational, from head-flit TDEST):
  - dx > X_COORD → EAST
  - dx < X_COORD → WEST
  - else dy > Y_COORD → NORTH
  - else dy < Y_COORD → SOUTH
  - else LOCAL
  - Comparisons are unsigned.
- State machine:
  - IDLE: route = route_fn(head). On handshake with tlast=0, latch route_q and go to LOCKED. On handshake with tlast=1, stay in IDLE.
  - LOCKED: route = route_q; TDEST of body flits is ignored. On handshake with tlast=1, go to IDLE.
- Output signals:
  - m_tvalid = (count != 0) ? onehot(route) : 5'b0. Exactly one bit is set at most.
  - m_* payload = FIFO head.
  - Only m_tready[route] is observed; the other ready bits are ignored.
- Valid stability: once m_tvalid is asserted, the payload and route stay stable until handshake. The head cannot change without a pop.
- Empty FIFO in LOCKED: m_tvalid=0, state held; resume when the next flit arrives.
- Single-flit packet (tlast on head): no LOCKED entry.
- PMU counters:
  - pmu_flits increments on each output handshake.
  - pmu_stall increments when m_tvalid != 0 && !m_tready[route].
  - Both saturate at all-ones.
  - pmu_clr has priority over increment (counter reads 0 the next cycle).
- Reset mid-packet: FIFO contents discarded, state returns to IDLE. The next accepted flit is treated as a head.

Test Plan:
- Single-flit routing, X_COORD=1, Y_COORD=1, X_BITS=2: send tdest 4'b0110, 4'b0100, 4'b1001, 4'b0001, 4'b0101 (each tlast=1) with all m_tready=1 → m_tvalid = 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001 in order; pmu_flits=5.
- Packet lock: 3-flit packet, head tdest 4'b0110, body flits tdest 4'b0000 → all three flits on EAST; state back to IDLE after tlast; next head 4'b0101 goes to LOCAL.
- Backpressure / full, FIFO_DEPTH=4: hold m_tready=0 and stream 6 flits → s_tready drops after 4 accepted; pmu_stall counts each held cycle. Release ready → flits drain in order, data intact, no loss or duplication.
- Simultaneous push/pop at full: m_tready=1 and s_tvalid=1 continuously → throughput 1 flit/cycle after the first. s_tready stays 0 until the first pop reduces count.
- Reset mid-packet: assert ARESETn=0 after the head of a 4-flit EAST packet → m_tvalid=0, counters 0, s_tready=1 immediately. After release, a tdest 4'b0100 single flit goes WEST.
- PMU saturation/clear, CNT_WIDTH=4: forward 20 flits → pmu_flits=15. pmu_clr pulse in the same cycle as a handshake → pmu_flits=0 the next cycle.
